// File: rtl/bus_condition_detector.sv
// I2C bus condition detector: synchronizes SCL/SDA, then reports SCL edges, START/STOP and bus busy.
// Optional glitch filter on both lines is enabled by defining GLITCH_FILTER_EN.
module bus_condition_detector #(
    parameter int FILTER_LEN = 3
) (
    input  logic clk,
    input  logic n_rst,
    input  logic scl,
    input  logic sda_in,
    output logic sda_sync,
    output logic rising_edge,
    output logic falling_edge,
    output logic start,
    output logic stop,
    output logic bus_busy
);

    if (FILTER_LEN < 2 || FILTER_LEN > 15) begin : g_filter_len_check
        $error("FILTER_LEN must be in 2..15");
    end

    logic [1:0] scl_meta;
    logic [1:0] sda_meta;
    logic       scl_s;
    logic       sda_s;
    logic       scl_c;
    logic       sda_c;
    logic       scl_p;
    logic       sda_p;

    // Both stages reset high so the bus looks idle on reset release.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            scl_meta <= 2'b11;
            sda_meta <= 2'b11;
        end else begin
            scl_meta <= {scl_meta[0], scl};
            sda_meta <= {sda_meta[0], sda_in};
        end
    end

    assign scl_s = scl_meta[1];
    assign sda_s = sda_meta[1];

`ifdef GLITCH_FILTER_EN
    localparam logic [3:0] CNT_LAST = 4'(FILTER_LEN - 1);

    logic [3:0] scl_cnt;
    logic [3:0] sda_cnt;

    // A new level is accepted only after it has persisted for FILTER_LEN cycles.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            scl_c   <= 1'b1;
            sda_c   <= 1'b1;
            scl_cnt <= 4'd0;
            sda_cnt <= 4'd0;
        end else begin
            if (scl_s != scl_c) begin
                if (scl_cnt == CNT_LAST) begin
                    scl_c   <= scl_s;
                    scl_cnt <= 4'd0;
                end else begin
                    scl_cnt <= scl_cnt + 4'd1;
                end
            end else begin
                scl_cnt <= 4'd0;
            end

            if (sda_s != sda_c) begin
                if (sda_cnt == CNT_LAST) begin
                    sda_c   <= sda_s;
                    sda_cnt <= 4'd0;
                end else begin
                    sda_cnt <= sda_cnt + 4'd1;
                end
            end else begin
                sda_cnt <= 4'd0;
            end
        end
    end
`else
    assign scl_c = scl_s;
    assign sda_c = sda_s;
`endif

    logic start_c;
    logic stop_c;

    // SDA transitions count as START/STOP only while SCL is stably high in both cycles.
    assign start_c = scl_p & scl_c & sda_p & ~sda_c;
    assign stop_c  = scl_p & scl_c & ~sda_p & sda_c;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            scl_p        <= 1'b1;
            sda_p        <= 1'b1;
            rising_edge  <= 1'b0;
            falling_edge <= 1'b0;
            start        <= 1'b0;
            stop         <= 1'b0;
            bus_busy     <= 1'b0;
        end else begin
            scl_p        <= scl_c;
            sda_p        <= sda_c;
            rising_edge  <= ~scl_p & scl_c;
            falling_edge <= scl_p & ~scl_c;
            start        <= start_c;
            stop         <= stop_c;
            bus_busy     <= start_c | (bus_busy & ~stop_c);
        end
    end

    assign sda_sync = sda_c;

endmodule
